// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-tick driven IDLE/PLAY/HIT/OVER game sequencer with lives, score and hit flash.
// Optional feature: define GAME_FLOW_PAUSE_EN to let a start press during PLAY toggle a pause.
module game_flow_ctrl #(
  parameter int LIVES_INIT = 3,
  parameter int HIT_FRAMES = 60,
  parameter int SCORE_DIV  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        collision,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  output logic [1:0]  game_state,
  output logic        obj_reset,
  output logic        move_en,
  output logic [1:0]  lives,
  output logic [11:0] score,
  output logic        flash
);
  localparam int FC_W = $clog2(SCORE_DIV);
  localparam logic [1:0]      LIVES_LD = 2'(LIVES_INIT);
  localparam logic [7:0]      HIT_LD   = 8'(HIT_FRAMES);
  localparam logic [FC_W-1:0] FC_MAX   = FC_W'(SCORE_DIV - 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_HIT = 2'b10, S_OVER = 2'b11} state_t;

  state_t          state_q, state_d;
  logic            start_q, start_prev_q, start_arm_q, start_arm_d;
  logic            tick_arm_q, tick_arm_d;
  logic            coll_q, coll_d, coll_in;
  logic [7:0]      hit_cnt_q, hit_cnt_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [11:0]     score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic            obj_reset_q, obj_reset_d, move_en_q, move_en_d, flash_q, flash_d;
  logic            at_origin, frame_tick, start_edge, paused;

`ifdef GAME_FLOW_PAUSE_EN
  logic paused_q, paused_d;
  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    at_origin   = (pxl_x == 32'd0) && (pxl_y == 32'd0);
    frame_tick  = at_origin && tick_arm_q;
    tick_arm_d  = !at_origin;
    // start_arm only sets once the raw button has been seen low, so a press held through reset is not an edge
    start_edge  = start_q && !start_prev_q && start_arm_q;
    start_arm_d = start_arm_q || !start;
    coll_in     = collision && (state_q == S_PLAY) && !paused;
    coll_d      = frame_tick ? coll_in : (coll_q || coll_in);

    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
`ifdef GAME_FLOW_PAUSE_EN
    paused_d    = paused_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d     = S_PLAY;
          lives_d     = LIVES_LD;
          score_d     = 12'd0;
          frame_cnt_d = '0;
        end
      end
      S_PLAY: begin
        if (frame_tick && !paused) begin
          if (coll_q) begin
            lives_d = lives_q - 2'd1;
            if (lives_d == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d   = S_HIT;
              hit_cnt_d = HIT_LD;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (frame_cnt_q == FC_MAX && score_q != 12'hFFF) score_d = score_q + 12'd1;
          end
        end
`ifdef GAME_FLOW_PAUSE_EN
        // The frame decision wins a tie with a start press; the press only pauses if we stay in PLAY.
        if (start_edge && state_d == S_PLAY) paused_d = !paused_q;
`endif
      end
      S_HIT: begin
        if (frame_tick) begin
          hit_cnt_d = hit_cnt_q - 8'd1;
          if (hit_cnt_d == 8'd0) state_d = S_PLAY;
        end
      end
      S_OVER: begin
        if (start_edge) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Collision history never survives outside PLAY, so a fresh game or a HIT return starts clean.
    if (state_d != S_PLAY) begin
      coll_d = 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
      paused_d = 1'b0;
`endif
    end

    obj_reset_d = (state_d == S_IDLE) || (state_d == S_HIT);
`ifdef GAME_FLOW_PAUSE_EN
    move_en_d   = (state_d == S_PLAY) && !paused_d;
`else
    move_en_d   = (state_d == S_PLAY);
`endif
    flash_d     = (state_d == S_HIT) && hit_cnt_d[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      start_arm_q  <= 1'b0;
      tick_arm_q   <= 1'b0;
      coll_q       <= 1'b0;
      hit_cnt_q    <= 8'd0;
      frame_cnt_q  <= '0;
      score_q      <= 12'd0;
      lives_q      <= 2'd0;
      obj_reset_q  <= 1'b1;
      move_en_q    <= 1'b0;
      flash_q      <= 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
      paused_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      start_prev_q <= start_q;
      start_arm_q  <= start_arm_d;
      tick_arm_q   <= tick_arm_d;
      coll_q       <= coll_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      obj_reset_q  <= obj_reset_d;
      move_en_q    <= move_en_d;
      flash_q      <= flash_d;
`ifdef GAME_FLOW_PAUSE_EN
      paused_q     <= paused_d;
`endif
    end
  end

  assign game_state = state_q;
  assign obj_reset  = obj_reset_q;
  assign move_en    = move_en_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign flash      = flash_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: frame-level reference model, directed scenarios and randomized play.
module tb_game_flow_ctrl;
  localparam int LIVES = 3, HITF = 60, DIV = 64, SDIV = 2;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        reset, start, collision, start_s;
  logic [31:0] pxl_x, pxl_y;
  logic [1:0]  game_state, lives, s_state, s_lives;
  logic        obj_reset, move_en, flash, s_obj, s_mv, s_flash;
  logic [11:0] score, s_score;
  logic [18:0] got;

  int nvec = 0, nerr = 0;
  int m_state, m_lives, m_frames, m_hit_left, s_frames;
  bit m_paused, m_pending, s_on;

  always #5 clk = ~clk;

  game_flow_ctrl #(.LIVES_INIT(LIVES), .HIT_FRAMES(HITF), .SCORE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .collision(collision), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .game_state(game_state), .obj_reset(obj_reset), .move_en(move_en), .lives(lives),
    .score(score), .flash(flash));

  game_flow_ctrl #(.LIVES_INIT(LIVES), .HIT_FRAMES(HITF), .SCORE_DIV(SDIV)) u_sat (
    .clk(clk), .reset(reset), .start(start_s), .collision(1'b0), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .game_state(s_state), .obj_reset(s_obj), .move_en(s_mv), .lives(s_lives),
    .score(s_score), .flash(s_flash));

  assign got = {game_state, obj_reset, move_en, lives, score, flash};

  // ---------------- reference model (frame level) ----------------
  function automatic logic [18:0] model_outs();
    logic [1:0] st, lv; logic ob, mv, fl; logic [11:0] sc; int q;
    st = 2'(m_state);
    lv = 2'(m_lives);
    ob = (m_state == M_IDLE) || (m_state == M_HIT);
    mv = (m_state == M_PLAY) && !m_paused;
    fl = (m_state == M_HIT) && (((m_hit_left / 8) % 2) == 1);
    q  = m_frames / DIV;
    if (q > 4095) q = 4095;
    sc = 12'(q);
    return {st, ob, mv, lv, sc, fl};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_lives = 0; m_frames = 0; m_hit_left = 0; m_paused = 0; m_pending = 0;
  endtask

  task automatic model_start();
    case (m_state)
      M_IDLE: begin m_state = M_PLAY; m_lives = LIVES; m_frames = 0; m_pending = 0; end
      M_OVER: m_state = M_IDLE;
      M_PLAY: begin
`ifdef GAME_FLOW_PAUSE_EN
        m_paused = !m_paused;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic model_tick(input bit coll_tick);
    bit live;
    live = (m_state == M_PLAY) && !m_paused;
    if (live) begin
      if (m_pending) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_state = M_OVER;
        else begin m_state = M_HIT; m_hit_left = HITF; end
      end else begin
        m_frames = m_frames + 1;
      end
    end else if (m_state == M_HIT) begin
      m_hit_left = m_hit_left - 1;
      if (m_hit_left == 0) m_state = M_PLAY;
    end
    m_pending = coll_tick && live;
    if (m_state != M_PLAY) begin m_pending = 0; m_paused = 0; end
    if (s_on) s_frames = s_frames + 1;
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start = 1'b1; step();
    start = 1'b0; step();
    model_start();
  endtask

  // body cycles off-origin (optional collision on the first), then the tick cycle, then extra origin cycles
  task automatic do_frame(input int body, input bit cb, input bit ct, input int hold);
    pxl_x = 32'd10; pxl_y = 32'd5;
    for (int i = 0; i < body; i++) begin
      collision = (i == 0) && cb;
      step();
    end
    if (cb && m_state == M_PLAY && !m_paused) m_pending = 1;
    pxl_x = 32'd0; pxl_y = 32'd0; collision = ct;
    step();
    collision = 1'b0;
    model_tick(ct);
    for (int i = 1; i < hold; i++) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; start_s = 1'b0; collision = 1'b0; pxl_x = 0; pxl_y = 0;
    s_on = 0; s_frames = 0;
    repeat (3) step();
    model_reset();
    nvec++;
    if (got !== {2'b00, 1'b1, 1'b0, 2'b00, 12'd0, 1'b0}) begin
      nerr++; $display("FAIL reset_values: got %h required %h", got, {2'b00, 1'b1, 1'b0, 2'b00, 12'd0, 1'b0});
    end
    reset = 1'b0;
    do_frame(2, 0, 0, 1);
    do_frame(1, 0, 0, 1);
    nvec++;
    if (game_state !== 2'b00) begin
      nerr++; $display("FAIL start_held_thru_reset: got state %b required 00", game_state);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_start();
    press_start();
    do_frame(2, 0, 0, 1);
    nvec++;
    if ({game_state, lives, score, move_en} !== {2'b01, 2'd3, 12'd0, 1'b1}) begin
      nerr++; $display("FAIL start_play: got %h required %h", {game_state, lives, score, move_en}, {2'b01, 2'd3, 12'd0, 1'b1});
    end
    nvec++;
    if (got !== model_outs()) begin nerr++; $display("FAIL start_model: got %h required %h", got, model_outs()); end
  endtask

  task automatic test_score();
    repeat (128) do_frame(1, 0, 0, 1);
    nvec++;
    if (score !== 12'd2) begin nerr++; $display("FAIL score_128: got %0d required 2", score); end
    nvec++;
    if (got !== model_outs()) begin nerr++; $display("FAIL score_model: got %h required %h", got, model_outs()); end
  endtask

  task automatic test_hit();
    do_frame(3, 1, 0, 1);
    nvec++;
    if ({game_state, lives, flash, obj_reset, move_en} !== {2'b10, 2'd2, 1'b1, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL hit_entry: got %h required %h", {game_state, lives, flash, obj_reset, move_en}, {2'b10, 2'd2, 1'b1, 1'b1, 1'b0});
    end
    for (int i = 0; i < HITF; i++) begin
      do_frame(2, i[0], i[1], 1);
      nvec++;
      if (got !== model_outs()) begin nerr++; $display("FAIL hit_frame%0d: got %h required %h", i, got, model_outs()); end
    end
    nvec++;
    if ({game_state, lives} !== {2'b01, 2'd2}) begin
      nerr++; $display("FAIL hit_return: got %h required %h", {game_state, lives}, {2'b01, 2'd2});
    end
  endtask

  task automatic test_over();
    do_frame(2, 1, 0, 1);
    repeat (HITF) do_frame(1, 0, 0, 1);
    do_frame(2, 1, 0, 1);
    nvec++;
    if ({game_state, lives, obj_reset, move_en, score} !== {2'b11, 2'd0, 1'b0, 1'b0, 12'd2}) begin
      nerr++; $display("FAIL over_entry: got %h required %h", {game_state, lives, obj_reset, move_en, score}, {2'b11, 2'd0, 1'b0, 1'b0, 12'd2});
    end
    repeat (5) begin
      do_frame(2, 1, 1, 2);
      nvec++;
      if (got !== model_outs()) begin nerr++; $display("FAIL over_frozen: got %h required %h", got, model_outs()); end
    end
    press_start();
    nvec++;
    if ({game_state, obj_reset, move_en} !== {2'b00, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL over_to_idle: got %h required %h", {game_state, obj_reset, move_en}, {2'b00, 1'b1, 1'b0});
    end
  endtask

  task automatic test_coll_on_tick();
    press_start();
    do_frame(2, 0, 1, 1);
    nvec++;
    if ({game_state, lives} !== {2'b01, 2'd3}) begin
      nerr++; $display("FAIL tick_coll_same: got %h required %h", {game_state, lives}, {2'b01, 2'd3});
    end
    do_frame(2, 0, 0, 1);
    nvec++;
    if ({game_state, lives} !== {2'b10, 2'd2}) begin
      nerr++; $display("FAIL tick_coll_next: got %h required %h", {game_state, lives}, {2'b10, 2'd2});
    end
    nvec++;
    if (got !== model_outs()) begin nerr++; $display("FAIL tick_coll_model: got %h required %h", got, model_outs()); end
  endtask

  task automatic test_reset_midgame();
    pxl_x = 32'd7; pxl_y = 32'd1; step();
    pxl_x = 32'd0; pxl_y = 32'd0; reset = 1'b1; step();
    reset = 1'b0;
    model_reset();
    step();
    nvec++;
    if (got !== {2'b00, 1'b1, 1'b0, 2'b00, 12'd0, 1'b0}) begin
      nerr++; $display("FAIL reset_midgame: got %h required %h", got, {2'b00, 1'b1, 1'b0, 2'b00, 12'd0, 1'b0});
    end
  endtask

  task automatic test_pause();
    press_start();
    do_frame(1, 0, 0, 1);
    press_start();
    nvec++;
    if (got !== model_outs()) begin nerr++; $display("FAIL pause_press1: got %h required %h", got, model_outs()); end
`ifdef GAME_FLOW_PAUSE_EN
    nvec++;
    if ({game_state, move_en} !== {2'b01, 1'b0}) begin
      nerr++; $display("FAIL pause_on: got %h required %h", {game_state, move_en}, {2'b01, 1'b0});
    end
`endif
    do_frame(2, 1, 0, 1);
    nvec++;
    if (got !== model_outs()) begin nerr++; $display("FAIL pause_coll: got %h required %h", got, model_outs()); end
`ifdef GAME_FLOW_PAUSE_EN
    nvec++;
    if (lives !== 2'd3) begin nerr++; $display("FAIL pause_lives: got %0d required 3", lives); end
`endif
    press_start();
    nvec++;
    if (got !== model_outs()) begin nerr++; $display("FAIL pause_press2: got %h required %h", got, model_outs()); end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0 || ((m_state == M_IDLE || m_state == M_OVER) && r < 6)) begin
        press_start();
        nvec++;
        if (got !== model_outs()) begin nerr++; $display("FAIL rand_start%0d: got %h required %h", n, got, model_outs()); end
      end
      do_frame(int'($urandom_range(1, 3)), $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
               int'($urandom_range(1, 3)));
      nvec++;
      if (got !== model_outs()) begin nerr++; $display("FAIL rand_frame%0d: got %h required %h", n, got, model_outs()); end
    end
  endtask

  task automatic test_saturate();
    int exp_sc;
    start_s = 1'b1; step();
    start_s = 1'b0; step();
    s_on = 1; s_frames = 0;
    nvec++;
    if ({s_state, s_score} !== {2'b01, 12'd0}) begin
      nerr++; $display("FAIL sat_start: got %h required %h", {s_state, s_score}, {2'b01, 12'd0});
    end
    while (s_frames < 4095 * SDIV + SDIV) begin
      do_frame(1, 0, 0, 1);
      if (s_frames == 4095 * SDIV - 1 || s_frames >= 4095 * SDIV) begin
        exp_sc = s_frames / SDIV;
        if (exp_sc > 4095) exp_sc = 4095;
        nvec++;
        if (s_score !== 12'(exp_sc)) begin
          nerr++; $display("FAIL sat_score@%0d: got %0d required %0d", s_frames, s_score, exp_sc);
        end
      end
    end
    nvec++;
    if (got !== model_outs()) begin nerr++; $display("FAIL sat_main_model: got %h required %h", got, model_outs()); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score();
    test_hit();
    test_over();
    test_coll_on_tick();
    test_reset_midgame();
    test_pause();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
